common_sdp_ram_be: RTL

Single-clock simple dual-port RAM with per-byte write enables, read-during-write bypass, a read-valid pipeline and a hardware clear sequencer. It is the successor to the plain inferred SDP RAM primitive. Use it for line buffers, weight/feature scratchpads and landmark result stores inside the vision pipeline wherever byte-granular updates, deterministic post-reset contents or a qualified read stream are needed.

---
 rtl/common_sdp_ram_be_pkg.sv | 18 +
 rtl/common_sdp_ram_lane.sv | 34 +++
 rtl/common_sdp_ram_be.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/common_sdp_ram_be_pkg.sv
// Shared types and constants for the byte-enable simple dual-port RAM.
// Holds the clear-FSM encoding, mode strings and the read-latency helper.
package common_sdp_ram_be_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_CLEAR = 2'd2
   } clr_state_e;

   localparam string MODE_TRUE  = "TRUE";
   localparam string MODE_FALSE = "FALSE";

   function automatic int unsigned read_latency(input bit output_reg_en);
      return output_reg_en ? 32'd2 : 32'd1;
   endfunction

endpackage

// File: rtl/common_sdp_ram_lane.sv
// One byte lane: 8-bit single-clock SDP array with registered read-first output.
// The output register only loads on an accepted read and clears on reset.
module common_sdp_ram_lane #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [7:0]            rdata
);

   logic [7:0] mem_r [0:(1<<ADDR_WIDTH)-1];

   // Array write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Array read port, holds between accepted reads
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rdata <= 8'h00;
      end else if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/common_sdp_ram_be.sv
// Simple dual-port RAM with byte enables, collision bypass, read-valid pipeline
// and a clear sequencer that sweeps CLEAR_VALUE through every word.
module common_sdp_ram_be
   import common_sdp_ram_be_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 9,
   parameter string                 OUTPUT_REG     = MODE_TRUE,
   parameter string                 BYPASS         = MODE_TRUE,
   parameter string                 CLEAR_ON_RESET = MODE_TRUE,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   input  logic                    clear_req,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid,
   output logic                    init_busy
);

   localparam int NB = DATA_WIDTH / 8;
   localparam bit OREG_EN = (OUTPUT_REG != MODE_FALSE);
   localparam bit BYP_EN  = (BYPASS != MODE_FALSE);
   localparam bit CLR_EN  = (CLEAR_ON_RESET != MODE_FALSE);
   localparam int unsigned RD_LAT = read_latency(OREG_EN);
   localparam clr_state_e RST_STATE = CLR_EN ? ST_CLEAR : ST_READY;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   clr_state_e              state_r, state_s;
   logic [ADDR_WIDTH-1:0]   sweep_addr_r, sweep_addr_s;
   logic                    init_busy_r;
   logic                    clearing_s, ready_s, wr_acc_s, rd_acc_s, coll_s;
   logic [NB-1:0]           lane_we_s;
   logic [ADDR_WIDTH-1:0]   lane_waddr_s;
   logic [DATA_WIDTH-1:0]   lane_wdata_s, lane_q_s, merged_s;
   logic [NB-1:0]           byp_mask_r;
   logic [DATA_WIDTH-1:0]   byp_data_r;
   logic                    v1_r;

   // Gating with rstn keeps the array untouched while reset is held
   assign clearing_s = rstn && (state_r == ST_CLEAR);
   assign ready_s    = rstn && (state_r == ST_READY);
   assign wr_acc_s   = we && ready_s;
   assign rd_acc_s   = re && ready_s;
   assign coll_s     = BYP_EN && rd_acc_s && wr_acc_s && (waddr == raddr);

   // Clear FSM state and sweep address register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r      <= RST_STATE;
         sweep_addr_r <= {ADDR_WIDTH{1'b0}};
         init_busy_r  <= CLR_EN;
      end else begin
         state_r      <= state_s;
         sweep_addr_r <= sweep_addr_s;
         init_busy_r  <= (state_s != ST_READY);
      end
   end

   // Clear FSM next state; a clear_req always restarts the sweep at 0
   always_comb begin
      state_s      = state_r;
      sweep_addr_s = sweep_addr_r;
      case (state_r)
         ST_IDLE: begin
            state_s = ST_READY;
         end
         ST_READY: begin
            if (clear_req) begin
               state_s      = ST_CLEAR;
               sweep_addr_s = {ADDR_WIDTH{1'b0}};
            end else begin
               state_s = ST_READY;
            end
         end
         ST_CLEAR: begin
            if (clear_req) begin
               sweep_addr_s = {ADDR_WIDTH{1'b0}};
            end else if (sweep_addr_r == LAST_ADDR) begin
               state_s      = ST_READY;
               sweep_addr_s = {ADDR_WIDTH{1'b0}};
            end else begin
               sweep_addr_s = sweep_addr_r + ADDR_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Write-port mux: the sweep owns the array while clearing
   always_comb begin
      if (clearing_s) begin
         lane_we_s    = {NB{1'b1}};
         lane_waddr_s = sweep_addr_r;
         lane_wdata_s = CLEAR_VALUE;
      end else begin
         lane_we_s    = wr_acc_s ? wbe : {NB{1'b0}};
         lane_waddr_s = waddr;
         lane_wdata_s = wdata;
      end
   end

   for (genvar i = 0; i < NB; i++) begin : g_lane
      common_sdp_ram_lane #(
         .ADDR_WIDTH(ADDR_WIDTH)
      ) u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .we    (lane_we_s[i]),
         .waddr (lane_waddr_s),
         .wdata (lane_wdata_s[8*i +: 8]),
         .re    (rd_acc_s),
         .raddr (raddr),
         .rdata (lane_q_s[8*i +: 8])
      );
   end

   // First read stage: valid flag plus the bytes to splice in on collision
   always_ff @(posedge clk) begin
      if (!rstn) begin
         v1_r       <= 1'b0;
         byp_mask_r <= {NB{1'b0}};
         byp_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         v1_r <= rd_acc_s;
         if (rd_acc_s) begin
            byp_mask_r <= coll_s ? wbe : {NB{1'b0}};
            byp_data_r <= wdata;
         end
      end
   end

   // Bypass merge of the lanes' read-first data with the colliding write bytes
   always_comb begin
      merged_s = lane_q_s;
      for (int i = 0; i < NB; i++) begin
         if (byp_mask_r[i]) begin
            merged_s[8*i +: 8] = byp_data_r[8*i +: 8];
         end else begin
            merged_s[8*i +: 8] = lane_q_s[8*i +: 8];
         end
      end
   end

   if (RD_LAT == 32'd2) begin : g_oreg
      logic [DATA_WIDTH-1:0] rdata_r;
      logic                  rvalid_r;

      // Second read register, loads only behind an accepted read
      always_ff @(posedge clk) begin
         if (!rstn) begin
            rdata_r  <= {DATA_WIDTH{1'b0}};
            rvalid_r <= 1'b0;
         end else begin
            rvalid_r <= v1_r;
            if (v1_r) begin
               rdata_r <= merged_s;
            end
         end
      end

      assign rdata  = rdata_r;
      assign rvalid = rvalid_r;
   end else begin : g_noreg
      assign rdata  = merged_s;
      assign rvalid = v1_r;
   end

   assign init_busy = init_busy_r;

endmodule
